// File: rtl/alut_pkg.sv
// Shared definitions for the ALUT address checker: entry layout, broadcast MAC,
// FSM encodings and the index hash.
package alut_pkg;

    localparam int VALID_BIT = 82;
    localparam int TIME_MSB  = 81;
    localparam int TIME_LSB  = 50;
    localparam int PORT_MSB  = 49;
    localparam int PORT_LSB  = 48;
    localparam int MAC_MSB   = 47;

    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DST_RD  = 3'd1,
        ST_DST_CHK = 3'd2,
        ST_AGE_REQ = 3'd3,
        ST_DST_INV = 3'd4,
        ST_SRC_WR  = 3'd5,
        ST_RSP     = 3'd6
    } alut_state_e;

    // Byte-wise XOR fold of a MAC into a table index.
    function automatic logic [7:0] alut_hash_fn(input logic [47:0] a);
        return a[47:40] ^ a[39:32] ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0];
    endfunction

    function automatic logic [82:0] make_entry(input logic [31:0] t,
                                               input logic [1:0]  p,
                                               input logic [47:0] m);
        return {1'b1, t, p, m};
    endfunction

endpackage

// File: rtl/alut_hash.sv
// Combinational 48-to-8 XOR fold used to index the ALUT.
module alut_hash
    import alut_pkg::*;
(
    input  logic [47:0] i_mac,
    output logic [7:0]  o_idx
);

    assign o_idx = alut_hash_fn(i_mac);

endmodule

// File: rtl/alut_addr_checker.sv
// ALUT address checker: destination lookup, age qualification through the age
// checker, stale-entry invalidation and source learning.
module alut_addr_checker
    import alut_pkg::*;
#(
    parameter int MEM_AW = 8,
    parameter int MEM_DW = 83,
    parameter int TIME_W = 32
)
(
    input  logic              pclk,
    input  logic              p_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [47:0]       req_d_addr,
    input  logic [47:0]       req_s_addr,
    input  logic [1:0]        req_s_port,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_port,
    output logic              rsp_bcast,
    input  logic [TIME_W-1:0] curr_time,
    input  logic              age_check_active,
    output logic              check_age,
    output logic [TIME_W-1:0] last_accessed,
    input  logic              age_confirmed,
    input  logic              age_ok,
    output logic [MEM_AW-1:0] mem_addr_add,
    output logic              mem_write_add,
    output logic [MEM_DW-1:0] mem_write_data_add,
    input  logic [MEM_DW-1:0] mem_read_data_add,
    output logic              add_check_active
);

    alut_state_e r_state;
    logic [47:0] r_d_addr;
    logic [47:0] r_s_addr;
    logic [1:0]  r_s_port;
    logic [1:0]  r_port;
    logic        r_bcast;

    logic [47:0] w_da_sel;
    logic [47:0] w_sa_sel;
    logic [7:0]  w_da_idx;
    logic [7:0]  w_sa_idx;
    logic        w_hit;

    // In IDLE the request is not captured yet, so hash straight from the inputs.
    assign w_da_sel = (r_state == ST_IDLE) ? req_d_addr : r_d_addr;
    assign w_sa_sel = (r_state == ST_IDLE) ? req_s_addr : r_s_addr;

    alut_hash u_hash_da (.i_mac(w_da_sel), .o_idx(w_da_idx));
    alut_hash u_hash_sa (.i_mac(w_sa_sel), .o_idx(w_sa_idx));

    assign w_hit = mem_read_data_add[VALID_BIT] &&
                   (mem_read_data_add[MAC_MSB:0] == r_d_addr);

    assign req_ready = (r_state == ST_IDLE) && !age_check_active;

    // Lookup/learn sequencer; every output register is set on the edge that enters its state.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            r_state            <= ST_IDLE;
            r_d_addr           <= 48'd0;
            r_s_addr           <= 48'd0;
            r_s_port           <= 2'd0;
            r_port             <= 2'd0;
            r_bcast            <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_port           <= 2'd0;
            rsp_bcast          <= 1'b0;
            check_age          <= 1'b0;
            last_accessed      <= '0;
            mem_addr_add       <= '0;
            mem_write_add      <= 1'b0;
            mem_write_data_add <= '0;
            add_check_active   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_d_addr         <= req_d_addr;
                        r_s_addr         <= req_s_addr;
                        r_s_port         <= req_s_port;
                        r_port           <= 2'd0;
                        add_check_active <= 1'b1;
                        if (req_d_addr == BCAST_MAC) begin
                            r_bcast            <= 1'b1;
                            r_state            <= ST_SRC_WR;
                            mem_addr_add       <= w_sa_idx;
                            mem_write_add      <= 1'b1;
                            mem_write_data_add <= make_entry(curr_time, req_s_port, req_s_addr);
                        end else begin
                            r_bcast      <= 1'b0;
                            r_state      <= ST_DST_RD;
                            mem_addr_add <= w_da_idx;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DST_RD: begin
                    r_state <= ST_DST_CHK;
                end
                ST_DST_CHK: begin
                    if (w_hit) begin
                        r_port        <= mem_read_data_add[PORT_MSB:PORT_LSB];
                        last_accessed <= mem_read_data_add[TIME_MSB:TIME_LSB];
                        check_age     <= 1'b1;
                        r_state       <= ST_AGE_REQ;
                    end else begin
                        r_bcast            <= 1'b1;
                        r_state            <= ST_SRC_WR;
                        mem_addr_add       <= w_sa_idx;
                        mem_write_add      <= 1'b1;
                        mem_write_data_add <= make_entry(curr_time, r_s_port, r_s_addr);
                    end
                end
                ST_AGE_REQ: begin
                    if (age_confirmed) begin
                        check_age     <= 1'b0;
                        mem_write_add <= 1'b1;
                        if (age_ok) begin
                            r_state            <= ST_SRC_WR;
                            mem_addr_add       <= w_sa_idx;
                            mem_write_data_add <= make_entry(curr_time, r_s_port, r_s_addr);
                        end else begin
                            r_bcast            <= 1'b1;
                            r_state            <= ST_DST_INV;
                            mem_addr_add       <= w_da_idx;
                            mem_write_data_add <= 83'd0;
                        end
                    end else begin
                        r_state <= ST_AGE_REQ;
                    end
                end
                ST_DST_INV: begin
                    r_state            <= ST_SRC_WR;
                    mem_addr_add       <= w_sa_idx;
                    mem_write_add      <= 1'b1;
                    mem_write_data_add <= make_entry(curr_time, r_s_port, r_s_addr);
                end
                ST_SRC_WR: begin
                    mem_write_add <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_bcast     <= r_bcast;
                    rsp_port      <= r_bcast ? 2'd0 : r_port;
                    r_state       <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid        <= 1'b0;
                        rsp_bcast        <= 1'b0;
                        rsp_port         <= 2'd0;
                        add_check_active <= 1'b0;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_state <= ST_RSP;
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    check_age        <= 1'b0;
                    mem_write_add    <= 1'b0;
                    rsp_valid        <= 1'b0;
                    add_check_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alut_addr_checker.sv
// Self-checking bench: behavioural ALUT model, emulated memory and age checker.
module tb_alut_addr_checker;

    logic        pclk = 1'b0;
    logic        p_reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] req_d_addr = 48'd0;
    logic [47:0] req_s_addr = 48'd0;
    logic [1:0]  req_s_port = 2'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_port;
    logic        rsp_bcast;
    logic [31:0] curr_time = 32'd0;
    logic        age_check_active = 1'b0;
    logic        check_age;
    logic [31:0] last_accessed;
    logic        age_confirmed = 1'b0;
    logic        age_ok = 1'b0;
    logic [7:0]  mem_addr_add;
    logic        mem_write_add;
    logic [82:0] mem_write_data_add;
    logic [82:0] mem_read_data_add = 83'd0;
    logic        add_check_active;

    alut_addr_checker dut (
        .pclk(pclk), .p_reset(p_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_d_addr(req_d_addr), .req_s_addr(req_s_addr), .req_s_port(req_s_port),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port), .rsp_bcast(rsp_bcast),
        .curr_time(curr_time), .age_check_active(age_check_active),
        .check_age(check_age), .last_accessed(last_accessed),
        .age_confirmed(age_confirmed), .age_ok(age_ok),
        .mem_addr_add(mem_addr_add), .mem_write_add(mem_write_add),
        .mem_write_data_add(mem_write_data_add), .mem_read_data_add(mem_read_data_add),
        .add_check_active(add_check_active)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [82:0] mem [256];
    logic [82:0] exp_mem [256];
    logic        tb_clr = 1'b1;
    logic        chk_en = 1'b0;
    logic        busy = 1'b0;

    logic        exp_bcast = 1'b0;
    logic [1:0]  exp_port = 2'd0;
    logic        exp_hit = 1'b0;
    logic [31:0] exp_last = 32'd0;
    int          exp_lat = 0;
    logic [7:0]  exp_wa [$];
    logic [82:0] exp_wd [$];
    logic [7:0]  act_wa [$];
    logic [82:0] act_wd [$];

    logic        tb_age_ok = 1'b1;
    int          age_delay = 2;
    int          age_n = 0;
    logic [31:0] age_last = 32'd0;

    task automatic check(input string nm, input logic [82:0] act, input logic [82:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] tb_hash(input logic [47:0] a);
        logic [7:0] h;
        h = 8'd0;
        for (int i = 0; i < 6; i++) h = h ^ a[i*8 +: 8];
        return h;
    endfunction

    // Emulated ALUT memory: write on strobe, read data one cycle after the address.
    always @(posedge pclk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 83'd0;
        end else if (mem_write_add) begin
            mem[mem_addr_add] <= mem_write_data_add;
        end
        mem_read_data_add <= mem[mem_addr_add];
    end

    // Emulated age checker: answers after age_delay cycles of check_age.
    always @(posedge pclk) begin
        int cnt;
        #1;
        if (check_age && !age_confirmed) begin
            cnt = cnt + 1;
            if (cnt == age_delay) begin
                age_confirmed = 1'b1;
                age_ok = tb_age_ok;
                age_last = last_accessed;
                age_n = age_n + 1;
            end
        end else begin
            cnt = 0;
            age_confirmed = 1'b0;
            age_ok = 1'b0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model's expectations.
    always @(negedge pclk) begin
        if (!p_reset && mem_write_add) begin
            act_wa.push_back(mem_addr_add);
            act_wd.push_back(mem_write_data_add);
        end
        if (!p_reset && chk_en) begin
            check("add_check_active", 83'(add_check_active), 83'(busy));
            check("req_ready", 83'(req_ready), 83'(!busy && !age_check_active));
            if (rsp_valid) begin
                check("rsp_port", 83'(rsp_port), 83'(exp_port));
                check("rsp_bcast", 83'(rsp_bcast), 83'(exp_bcast));
            end
            if (!exp_hit) check("no_check_age", 83'(check_age), 83'd0);
        end
    end

    // Reference behaviour of one request, computed from the table contents.
    task automatic model_compute(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] port,
                                 input logic aok, input int adly, input logic [31:0] t);
        logic [82:0] e;
        logic [82:0] learn;
        learn = {1'b1, t, port, sa};
        exp_wa.delete();
        exp_wd.delete();
        exp_hit = 1'b0;
        exp_port = 2'd0;
        if (da == 48'hffff_ffff_ffff) begin
            exp_bcast = 1'b1;
            exp_lat = 3;
        end else begin
            e = exp_mem[tb_hash(da)];
            if (e[82] && e[47:0] == da) begin
                exp_hit = 1'b1;
                exp_last = e[81:50];
                if (aok) begin
                    exp_bcast = 1'b0;
                    exp_port = e[49:48];
                    exp_lat = 5 + adly;
                end else begin
                    exp_bcast = 1'b1;
                    exp_lat = 6 + adly;
                    exp_wa.push_back(tb_hash(da));
                    exp_wd.push_back(83'd0);
                end
            end else begin
                exp_bcast = 1'b1;
                exp_lat = 5;
            end
        end
        exp_wa.push_back(tb_hash(sa));
        exp_wd.push_back(learn);
    endtask

    task automatic model_apply();
        for (int i = 0; i < exp_wa.size(); i++) exp_mem[exp_wa[i]] = exp_wd[i];
    endtask

    task automatic run_txn(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] port,
                           input logic aok, input int adly, input int rdly,
                           input logic [31:0] t, input int blk);
        int n;
        int lat;
        int wr_base;
        int age_base;
        model_compute(da, sa, port, aok, adly, t);
        wr_base = act_wa.size();
        age_base = age_n;
        @(posedge pclk); #1;
        curr_time = t; tb_age_ok = aok; age_delay = adly;
        req_d_addr = da; req_s_addr = sa; req_s_port = port; req_valid = 1'b1;
        age_check_active = (blk > 0);
        for (int i = 0; i < blk; i++) begin
            @(negedge pclk);
            check("blocked_no_mem_addr_change", 83'(add_check_active), 83'd0);
            @(posedge pclk); #1;
        end
        age_check_active = 1'b0;
        n = 0;
        @(negedge pclk);
        while (!req_ready && n < 20) begin @(negedge pclk); n++; end
        if (n >= 20) check("accept_timeout", 83'd1, 83'd0);
        @(posedge pclk); #1;
        req_valid = 1'b0;
        busy = 1'b1;
        lat = 2;
        @(negedge pclk);
        while (!rsp_valid && lat < 60) begin @(negedge pclk); lat++; end
        check("latency", 83'(lat), 83'(exp_lat));
        repeat (rdly) @(negedge pclk);
        @(posedge pclk); #1;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        busy = 1'b0;
        @(negedge pclk);
        check("rsp_released", 83'(rsp_valid), 83'd0);
        check("wr_count", 83'(act_wa.size() - wr_base), 83'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size(); i++) begin
            if (wr_base + i < act_wa.size()) begin
                check("wr_addr", 83'(act_wa[wr_base + i]), 83'(exp_wa[i]));
                check("wr_data", act_wd[wr_base + i], exp_wd[i]);
            end
        end
        check("age_req_count", 83'(age_n - age_base), 83'(exp_hit));
        if (exp_hit) check("last_accessed", 83'(age_last), 83'(exp_last));
        model_apply();
    endtask

    logic [47:0] pool [6];
    logic [47:0] da_r;

    initial begin
        int n;
        int wr_base;
        for (int i = 0; i < 256; i++) exp_mem[i] = 83'd0;
        check("model_hash_fold", 83'(tb_hash(48'h0102_0304_0506)), 83'h07);
        check("model_hash_bcast", 83'(tb_hash(48'hffff_ffff_ffff)), 83'h00);
        repeat (3) @(posedge pclk);
        #2;
        p_reset = 1'b0;
        tb_clr = 1'b0;
        @(negedge pclk);
        check("rst_req_ready", 83'(req_ready), 83'd1);
        check("rst_rsp_valid", 83'(rsp_valid), 83'd0);
        check("rst_check_age", 83'(check_age), 83'd0);
        check("rst_mem_write", 83'(mem_write_add), 83'd0);
        check("rst_active", 83'(add_check_active), 83'd0);
        check("rst_mem_addr", 83'(mem_addr_add), 83'd0);
        chk_en = 1'b1;

        run_txn(48'h11, 48'h22, 2'd1, 1'b1, 2, 0, 32'h0000_1000, 0);
        check("t1_entry", mem[8'h22], {1'b1, 32'h0000_1000, 2'd1, 48'h22});
        run_txn(48'h22, 48'h11, 2'd2, 1'b1, 2, 0, 32'h0000_2000, 0);
        check("t2_last_literal", 83'(age_last), 83'h1000);
        check("t2_model_port", 83'(exp_port), 83'd1);
        run_txn(48'h22, 48'h11, 2'd2, 1'b0, 2, 0, 32'h0000_3000, 0);
        check("t3_invalidated", mem[8'h22], 83'd0);
        run_txn(48'h22, 48'h44, 2'd3, 1'b1, 2, 0, 32'h0000_4000, 0);
        check("t4_model_miss", 83'(exp_bcast), 83'd1);
        run_txn(48'hffff_ffff_ffff, 48'h55, 2'd0, 1'b1, 2, 0, 32'h0000_5000, 0);
        check("t5_bcast_learn", mem[8'h55], {1'b1, 32'h0000_5000, 2'd0, 48'h55});
        run_txn(48'h55, 48'h66, 2'd1, 1'b1, 2, 5, 32'h0000_6000, 4);
        run_txn(48'h66, 48'h66, 2'd2, 1'b0, 3, 0, 32'h0000_7000, 0);
        check("t7_same_idx_final", mem[8'h66], {1'b1, 32'h0000_7000, 2'd2, 48'h66});

        // Reset in the middle of an age check: nothing is written, nothing is applied to the model.
        model_compute(48'h55, 48'h77, 2'd3, 1'b1, 20, 32'h0000_8000);
        wr_base = act_wa.size();
        @(posedge pclk); #1;
        age_delay = 20;
        req_d_addr = 48'h55; req_s_addr = 48'h77; req_s_port = 2'd3; req_valid = 1'b1;
        @(posedge pclk); #1;
        req_valid = 1'b0;
        busy = 1'b1;
        n = 0;
        while (!check_age && n < 10) begin @(negedge pclk); n++; end
        check("rst_test_reached_age_req", 83'(check_age), 83'd1);
        @(posedge pclk); #2;
        p_reset = 1'b1;
        busy = 1'b0;
        #1;
        check("midrst_check_age", 83'(check_age), 83'd0);
        check("midrst_active", 83'(add_check_active), 83'd0);
        check("midrst_mem_write", 83'(mem_write_add), 83'd0);
        @(negedge pclk);
        check("midrst_no_write", 83'(act_wa.size() - wr_base), 83'd0);
        @(posedge pclk); #2;
        p_reset = 1'b0;
        run_txn(48'h55, 48'h77, 2'd3, 1'b1, 2, 0, 32'h0000_9000, 0);

        for (int i = 0; i < 6; i++) pool[i] = {16'($urandom), $urandom};
        pool[5] = pool[0] ^ 48'h0101_0000_0000;
        for (int k = 0; k < 150; k++) begin
            da_r = ($urandom_range(0, 9) == 0) ? 48'hffff_ffff_ffff : pool[$urandom_range(0, 5)];
            run_txn(da_r, pool[$urandom_range(0, 5)], 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(0, 3),
                    $urandom, ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
